// File: rtl/traffic_light_monitor.sv
// Passive checker for the cyclic lamp bus: validates one-hot encoding, G->Y->R order
// and per-phase dwell bounds, raising sticky error flags and counting completed cycles.
module traffic_light_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 4,
    parameter int DWELL_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dwell,
    output logic [CNT_W-1:0] cycle_count
);

    // state   | meaning
    // IDLE    | waiting for first green, no checking
    // GREEN   | tracking green phase
    // YELLOW  | tracking yellow phase
    // RED     | tracking red phase
    // FAULT   | violation seen, held until clr_err or reset
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [2:0] CODE_G = 3'b001;
    localparam logic [2:0] CODE_Y = 3'b010;
    localparam logic [2:0] CODE_R = 3'b100;

    localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0] ONE_D = DWELL_W'(1);

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] dwell, dwell_nxt;
    logic               set_illegal, set_seq, set_dwell, inc_cycle;
    logic [2:0]         cur_code, next_code;
    state_t             next_phase;
    logic               code_legal;

    assign code_legal = (light == CODE_G) || (light == CODE_Y) || (light == CODE_R);

    always_comb begin
        cur_code   = CODE_G;
        next_code  = CODE_Y;
        next_phase = S_YELLOW;
        case (state)
            S_YELLOW: begin
                cur_code   = CODE_Y;
                next_code  = CODE_R;
                next_phase = S_RED;
            end
            S_RED: begin
                cur_code   = CODE_R;
                next_code  = CODE_G;
                next_phase = S_GREEN;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell;
        set_illegal = 1'b0;
        set_seq     = 1'b0;
        set_dwell   = 1'b0;
        inc_cycle   = 1'b0;
        case (state)
            S_IDLE: begin
                if (light == CODE_G) begin
                    state_nxt = S_GREEN;
                    dwell_nxt = ONE_D;
                end
            end
            S_GREEN, S_YELLOW, S_RED: begin
                if (!code_legal) begin
                    set_illegal = 1'b1;
                    state_nxt   = S_FAULT;
                    dwell_nxt   = '0;
                end else if (light == cur_code) begin
                    if (dwell == MAX_D) begin
                        set_dwell = 1'b1;
                        state_nxt = S_FAULT;
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell + ONE_D;
                    end
                end else if (light == next_code) begin
                    if (dwell < MIN_D) begin
                        set_dwell = 1'b1;
                        state_nxt = S_FAULT;
                        dwell_nxt = '0;
                    end else begin
                        state_nxt = next_phase;
                        dwell_nxt = ONE_D;
                        inc_cycle = (state == S_RED);
                    end
                end else begin
                    set_seq   = 1'b1;
                    state_nxt = S_FAULT;
                    dwell_nxt = '0;
                end
            end
            default: ;
        endcase
        // clr_err overrides any violation or advance decided above
        if (clr_err) begin
            state_nxt = S_IDLE;
            dwell_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            dwell       <= '0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_dwell   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            dwell <= dwell_nxt;
            if (clr_err) begin
                err_illegal <= 1'b0;
                err_seq     <= 1'b0;
                err_dwell   <= 1'b0;
                cycle_count <= '0;
            end else begin
                err_illegal <= err_illegal | set_illegal;
                err_seq     <= err_seq | set_seq;
                err_dwell   <= err_dwell | set_dwell;
                if (inc_cycle) begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        phase  = 2'b11;
        locked = 1'b0;
        fault  = 1'b0;
        case (state)
            S_GREEN: begin
                phase  = 2'b00;
                locked = 1'b1;
            end
            S_YELLOW: begin
                phase  = 2'b01;
                locked = 1'b1;
            end
            S_RED: begin
                phase  = 2'b10;
                locked = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: two instances (MIN_DWELL 1 and 2),
// directed lamp sequences with hand-computed expected outputs.
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  light_a = 3'b000, light_b = 3'b000;
    logic        clr_a = 1'b0, clr_b = 1'b0;
    logic [1:0]  phase_a, phase_b;
    logic        locked_a, locked_b, fault_a, fault_b;
    logic        ei_a, ei_b, es_a, es_b, ed_a, ed_b;
    logic [15:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          which;
        string       name;
        logic [1:0]  ph;
        logic        lk, ft, ei, es, ed;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .DWELL_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .light(light_a), .clr_err(clr_a),
        .phase(phase_a), .locked(locked_a), .fault(fault_a),
        .err_illegal(ei_a), .err_seq(es_a), .err_dwell(ed_a), .cycle_count(cnt_a)
    );

    traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(4), .DWELL_W(8), .CNT_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .light(light_b), .clr_err(clr_b),
        .phase(phase_b), .locked(locked_b), .fault(fault_b),
        .err_illegal(ei_b), .err_seq(es_b), .err_dwell(ed_b), .cycle_count(cnt_b)
    );

    task automatic compare(input string name, input logic [22:0] act, input logic [22:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got ph=%b lk=%b ft=%b ei=%b es=%b ed=%b cnt=%0d, want ph=%b lk=%b ft=%b ei=%b es=%b ed=%b cnt=%0d",
                     name, act[22:21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                     req[22:21], req[20], req[19], req[18], req[17], req[16], req[15:0]);
        end
    endtask

    // Monitor: every output update (after each rising edge) is checked against the queue.
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            logic [22:0] act;
            e = sb.pop_front();
            if (e.which == 0)
                act = {phase_a, locked_a, fault_a, ei_a, es_a, ed_a, cnt_a};
            else
                act = {phase_b, locked_b, fault_b, ei_b, es_b, ed_b, cnt_b};
            compare(e.name, act, {e.ph, e.lk, e.ft, e.ei, e.es, e.ed, e.cnt});
        end
    end

    task automatic step(input int which, input string name, input logic [2:0] l, input logic c,
                        input logic [1:0] ph, input logic lk, input logic ft,
                        input logic ei, input logic es, input logic ed, input int cnt);
        exp_t e;
        @(negedge clk);
        if (which == 0) begin
            light_a = l;
            clr_a   = c;
        end else begin
            light_b = l;
            clr_b   = c;
        end
        e.which = which; e.name = name; e.ph = ph; e.lk = lk; e.ft = ft;
        e.ei = ei; e.es = es; e.ed = ed; e.cnt = 16'(cnt);
        sb.push_back(e);
    endtask

    task automatic check_reset(input string name);
        compare({name, "_a"}, {phase_a, locked_a, fault_a, ei_a, es_a, ed_a, cnt_a}, {2'b11, 5'b0, 16'd0});
        compare({name, "_b"}, {phase_b, locked_b, fault_b, ei_b, es_b, ed_b, cnt_b}, {2'b11, 5'b0, 16'd0});
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // every-clock cycling: G,Y,R x4
        for (int k = 0; k < 4; k++) begin
            step(0, "cyc_g", G, 0, 2'b00, 1, 0, 0, 0, 0, k);
            step(0, "cyc_y", Y, 0, 2'b01, 1, 0, 0, 0, 0, k);
            step(0, "cyc_r", R, 0, 2'b10, 1, 0, 0, 0, 0, k);
        end

        // illegal code while locked in GREEN; FAULT ignores further codes
        step(0, "pre_ill_g", G, 0, 2'b00, 1, 0, 0, 0, 0, 4);
        step(0, "illegal",   3'b011, 0, 2'b11, 0, 1, 1, 0, 0, 4);
        step(0, "fault_g",   G, 0, 2'b11, 0, 1, 1, 0, 0, 4);
        step(0, "fault_y",   Y, 0, 2'b11, 0, 1, 1, 0, 0, 4);
        step(0, "fault_r",   R, 0, 2'b11, 0, 1, 1, 0, 0, 4);
        step(0, "clr_fault", G, 1, 2'b11, 0, 0, 0, 0, 0, 0);

        // out-of-order G->R
        step(0, "seq_g", G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(0, "seq_r", R, 0, 2'b11, 0, 1, 0, 1, 0, 0);
        step(0, "clr_seq", 3'b000, 1, 2'b11, 0, 0, 0, 0, 0, 0);

        // MAX_DWELL=4: four greens then yellow is legal; five greens is not
        for (int k = 0; k < 4; k++) step(0, "hold4_g", G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(0, "hold4_y", Y, 0, 2'b01, 1, 0, 0, 0, 0, 0);
        step(0, "hold4_r", R, 0, 2'b10, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, "hold5_g", G, 0, 2'b00, 1, 0, 0, 0, 0, 1);
        step(0, "hold5_over", G, 0, 2'b11, 0, 1, 0, 0, 1, 1);
        step(0, "clr_dwell", 3'b000, 1, 2'b11, 0, 0, 0, 0, 0, 0);

        // run up to cycle_count=5 sitting in RED, then async reset
        for (int k = 0; k < 6; k++) begin
            step(0, "run_g", G, 0, 2'b00, 1, 0, 0, 0, 0, k);
            step(0, "run_y", Y, 0, 2'b01, 1, 0, 0, 0, 0, k);
            step(0, "run_r", R, 0, 2'b10, 1, 0, 0, 0, 0, k);
        end
        @(negedge clk);
        light_a = 3'b000;
        #2 reset_n = 1'b0;
        #1 check_reset("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;

        // resync only at green; IDLE flags nothing
        step(0, "rs_000", 3'b000, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        step(0, "rs_r",   R, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        step(0, "rs_y",   Y, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        step(0, "rs_g",   G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(0, "clr_vs_ill", 3'b111, 1, 2'b11, 0, 0, 0, 0, 0, 0);
        step(0, "idle_ill", 3'b111, 0, 2'b11, 0, 0, 0, 0, 0, 0);

        // MIN_DWELL=2 instance
        step(1, "b_clr",  3'b000, 1, 2'b11, 0, 0, 0, 0, 0, 0);
        step(1, "b_g",    G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(1, "b_short", Y, 0, 2'b11, 0, 1, 0, 0, 1, 0);
        step(1, "b_clr2", 3'b000, 1, 2'b11, 0, 0, 0, 0, 0, 0);
        step(1, "b_g1",   G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(1, "b_g2",   G, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        step(1, "b_y",    Y, 0, 2'b01, 1, 0, 0, 0, 0, 0);
        step(1, "b_y2",   Y, 0, 2'b01, 1, 0, 0, 0, 0, 0);
        step(1, "b_r",    R, 0, 2'b10, 1, 0, 0, 0, 0, 0);
        step(1, "b_r_short", G, 0, 2'b11, 0, 1, 0, 0, 1, 0);

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
